// File: rtl/buffer_column_sequencer.sv
// -----------------------------------------------------------------------------
// buffer_column_sequencer
//
// Purpose
//   Captures one tile of COLS columns from the transposed interpolation buffer
//   (each column ROWS signed samples of SAMPLE_W bits) on a valid/ready load
//   handshake. It then streams the columns, one per accepted output beat, to
//   the column filter stage in ascending or descending order.
//
// Optional feature
//   BUF_DOUBLE_BANK_EN : when defined, a shadow bank lets the next tile be
//   loaded while the current one drains. The banks swap on the last-column
//   handshake, so there is no bubble between tiles. When undefined, there is
//   one bank and no shadow storage is built.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   synchronous discard of all tile state (same effect as reset)
//   load_valid in   tile on data_in is valid
//   load_ready out  block can accept a tile
//   load_rev   in   column order for the loaded tile (0 ascending, 1 descending)
//   data_in    in   tile; column c occupies [c*COL_W +: COL_W]
//   out_valid  out  data_out holds a valid column
//   out_ready  in   consumer accepts the column
//   data_out   out  selected column (signed), 0 whenever out_valid=0
//   out_col    out  index of the column on data_out
//   out_last   out  final column of the tile
//   dbg_state  out  FSM state (0 IDLE, 1 DRAIN)
//
// Handshake semantics (both ports)
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Once valid is raised, the producer holds it and the payload stable until
//   that transfer. Ready may change freely and never depends on valid in the
//   same cycle. Here load_ready depends only on registered state.
// -----------------------------------------------------------------------------
module buffer_column_sequencer #(
  parameter  int SAMPLE_W = 11,
  parameter  int ROWS     = 9,
  parameter  int COLS     = 4,
  localparam int COL_W    = ROWS * SAMPLE_W,
  localparam int CNT_W    = $clog2(COLS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      load_rev,
  input  logic [COLS*COL_W-1:0]     data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COL_W-1:0]   data_out,
  output logic [CNT_W-1:0]          out_col,
  output logic                      out_last,
  output logic                      dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state;
  logic [COLS*COL_W-1:0]   active_bank;
  logic                    active_rev;

`ifdef BUF_DOUBLE_BANK_EN
  logic [COLS*COL_W-1:0]   shadow_bank;
  logic                    shadow_rev;
  logic                    shadow_full;
`endif

  // Column index helpers. The index only moves inside [0, COLS-1], because
  // the last column always ends the tile instead of stepping past it.
  function automatic logic [CNT_W-1:0] first_col(input logic rev);
    return rev ? CNT_W'(COLS - 1) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] last_col(input logic rev);
    return rev ? '0 : CNT_W'(COLS - 1);
  endfunction

  function automatic logic [CNT_W-1:0] next_col(input logic [CNT_W-1:0] c,
                                                input logic             rev);
    return rev ? (c - 1'b1) : (c + 1'b1);
  endfunction

  function automatic logic [COL_W-1:0] pick(input logic [COLS*COL_W-1:0] tile,
                                            input logic [CNT_W-1:0]      c);
    return tile[int'(c)*COL_W +: COL_W];
  endfunction

  logic load_fire;
  logic out_fire;
  logic last_fire;

  assign load_fire = load_valid && load_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_fire = out_fire && out_last;
  assign dbg_state = (state == DRAIN);

  // load_ready is derived only from flops. That keeps it glitch-free and
  // independent of load_valid.
`ifdef BUF_DOUBLE_BANK_EN
  assign load_ready = (state == IDLE) || !shadow_full;
`else
  assign load_ready = (state == IDLE);
`endif

  // Tile start selection. A new tile becomes active in three cases:
  //  - a load arrives in IDLE;
  //  - the shadow bank is promoted on the last-column handshake;
  //  - a load arrives together with the last-column handshake while the
  //    shadow bank is empty. In that case it bypasses the shadow bank.
  logic                  start_go;
  logic [COLS*COL_W-1:0] start_tile;
  logic                  start_rev;

  always_comb begin
    start_go   = 1'b0;
    start_tile = data_in;
    start_rev  = load_rev;
    case (state)
      IDLE: begin
        start_go = load_fire;
      end
      DRAIN: begin
`ifdef BUF_DOUBLE_BANK_EN
        if (last_fire) begin
          if (shadow_full) begin
            start_go   = 1'b1;
            start_tile = shadow_bank;
            start_rev  = shadow_rev;
          end else begin
            start_go = load_fire;
          end
        end
`endif
      end
      default: begin
        start_go = 1'b0;
      end
    endcase
  end

  // Main sequencer. Every output is registered. While out_ready=0 in DRAIN,
  // none of the branches below is taken, so the presented column is held.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      data_out   <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
      active_rev <= 1'b0;
    end else if (start_go) begin
      // COLS >= 2, so the first column of a tile is never its last.
      state       <= DRAIN;
      active_bank <= start_tile;
      active_rev  <= start_rev;
      out_valid   <= 1'b1;
      out_col     <= first_col(start_rev);
      data_out    <= pick(start_tile, first_col(start_rev));
      out_last    <= 1'b0;
    end else if (state == DRAIN && out_fire && !out_last) begin
      out_col  <= next_col(out_col, active_rev);
      data_out <= pick(active_bank, next_col(out_col, active_rev));
      out_last <= (next_col(out_col, active_rev) == last_col(active_rev));
    end else if (state == DRAIN && last_fire) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end
  end

`ifdef BUF_DOUBLE_BANK_EN
  // Shadow bank bookkeeping. A load in DRAIN fills the shadow bank, except
  // when it coincides with the last-column handshake. Then it goes straight
  // to the active bank (see start selection above).
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      shadow_full <= 1'b0;
      shadow_rev  <= 1'b0;
    end else if (state == DRAIN) begin
      if (last_fire && shadow_full) begin
        shadow_full <= 1'b0;
      end else if (load_fire && !last_fire) begin
        shadow_bank <= data_in;
        shadow_rev  <= load_rev;
        shadow_full <= 1'b1;
      end
    end
  end
`endif

endmodule
